// File: rtl/ucode_sequencer.sv
// Clocked microcode sequencer: fixed fetch step, then execute steps read from a
// writable control store indexed by {IR, C, Z, step}. Optional macro UCODE_PARITY_EN adds per-entry even parity.
module ucode_sequencer #(
    parameter int              OPC_W      = 4,
    parameter int              CW_W       = 13,
    parameter int              STEPS      = 4,
    parameter int              STEP_W     = $clog2(STEPS),
    parameter logic [CW_W-1:0] FETCH_WORD = 13'b1000000001000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [OPC_W-1:0]          opcode,
    input  logic                      flag_c,
    input  logic                      flag_z,
    input  logic                      halt_req,
    input  logic                      uc_we,
    input  logic [OPC_W+2+STEP_W-1:0] uc_addr,
`ifdef UCODE_PARITY_EN
    input  logic [CW_W+1:0]           uc_wdata,
`else
    input  logic [CW_W:0]             uc_wdata,
`endif
    output logic [CW_W-1:0]           ctrl_word,
    output logic [STEP_W-1:0]         step,
    output logic                      fetch,
    output logic                      halted,
    output logic                      par_err
);

    localparam int ADDR_W = OPC_W + 2 + STEP_W;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef UCODE_PARITY_EN
    localparam int ENTRY_W = CW_W + 2;
`else
    localparam int ENTRY_W = CW_W + 1;
`endif

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t              state_q;
    logic [STEP_W-1:0]   step_q;
    logic [OPC_W-1:0]    ir_q;
    logic [ENTRY_W-1:0]  store_q [DEPTH];
    logic [ENTRY_W-1:0]  entry_s;
    logic                entry_last_s;
    logic                entry_bad_s;
    logic [CW_W-1:0]     ctrl_s;

    // Odd total weight over the whole entry means the stored parity disagrees.
    function automatic logic parity_bad(input logic [ENTRY_W-1:0] e);
        return ^e;
    endfunction

    // Control store write port; deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (uc_we) begin
            store_q[uc_addr] <= uc_wdata;
        end
    end

    assign entry_s      = store_q[{ir_q, flag_c, flag_z, step_q}];
    assign entry_last_s = entry_s[CW_W];
`ifdef UCODE_PARITY_EN
    assign entry_bad_s  = parity_bad(entry_s);
`else
    assign entry_bad_s  = 1'b0;
`endif

    // Control word: live flags feed the store address, so EXEC words have no added latency.
    always_comb begin
        ctrl_s = {CW_W{1'b0}};
        case (state_q)
            ST_FETCH: ctrl_s = FETCH_WORD;
            ST_EXEC: begin
                if (entry_bad_s) begin
                    ctrl_s = {CW_W{1'b0}};
                end else begin
                    ctrl_s = entry_s[CW_W-1:0];
                end
            end
            ST_HALT:  ctrl_s = {CW_W{1'b0}};
            default:  ctrl_s = {CW_W{1'b0}};
        endcase
    end

    // Sequencer FSM: state, micro-step and instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            step_q  <= {STEP_W{1'b0}};
            ir_q    <= {OPC_W{1'b0}};
        end else if (en) begin
            case (state_q)
                ST_FETCH: begin
                    if (halt_req) begin
                        state_q <= ST_HALT;
                    end else begin
                        ir_q    <= opcode;
                        step_q  <= STEP_W'(1);
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (entry_last_s || (step_q == STEP_W'(STEPS - 1))) begin
                        step_q  <= {STEP_W{1'b0}};
                        state_q <= ST_FETCH;
                    end else begin
                        step_q  <= step_q + STEP_W'(1);
                    end
                end
                ST_HALT: begin
                    if (!halt_req) begin
                        step_q  <= {STEP_W{1'b0}};
                        state_q <= ST_FETCH;
                    end else begin
                        state_q <= ST_HALT;
                    end
                end
                default: begin
                    step_q  <= {STEP_W{1'b0}};
                    state_q <= ST_FETCH;
                end
            endcase
        end else begin
            state_q <= state_q;
        end
    end

`ifdef UCODE_PARITY_EN
    logic par_err_q;

    // Sticky parity error: any bad EXEC read latches until reset, independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if ((state_q == ST_EXEC) && entry_bad_s) begin
            par_err_q <= 1'b1;
        end else begin
            par_err_q <= par_err_q;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign ctrl_word = ctrl_s;
    assign step      = step_q;
    assign fetch     = (state_q == ST_FETCH);
    assign halted    = (state_q == ST_HALT);

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Parametrised, clocked successor to the combinational control ROM of the 4-bit CPU.
- Holds an instruction register (IR) and a micro-step counter, and drives the datapath control word each cycle.
- Reads execute-step words from a writable control store indexed by {IR, C, Z, step}.
- Step 0 is always the fixed fetch word. Instructions use 1 to STEPS-1 execute steps, ended by a per-entry "last" bit. Adds a halt state.

Parameters:
- OPC_W, 4, opcode width.
- CW_W, 13, control word width.
- STEPS, 4, maximum steps per instruction including fetch (power of 2, at least 2).
- STEP_W, $clog2(STEPS), step counter width.
- FETCH_WORD, 13'b1000000001000, control word driven during fetch step.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; when low, all state holds.
- opcode  in  OPC_W  instruction from program memory; sampled at the end of fetch.
- flag_c  in  1  carry flag, used live.
- flag_z  in  1  zero flag, used live.
- halt_req  in  1  halt request, sampled at fetch.
- uc_we  in  1  control store write strobe.
- uc_addr  in  OPC_W+2+STEP_W  store address {op, c, z, step}.
- uc_wdata  in  CW_W+1 (+1 with parity)  {last, ctrl}, parity bit as MSB when enabled.
- ctrl_word  out  CW_W  current control word.
- step  out  STEP_W  current micro-step.
- fetch  out  1  high in fetch step.
- halted  out  1  high in HALT.
- par_err  out  1  sticky parity error.

Behaviour:
- States: FETCH, EXEC, HALT. Reset (asynchronous, rst_n=0) forces FETCH, step=0, IR=0, par_err=0.
- Reset does not clear the control store.
- Outputs during reset: ctrl_word=FETCH_WORD, fetch=1, halted=0.
- FETCH:
  - ctrl_word=FETCH_WORD.
  - On an edge with en=1 and halt_req=0: IR<=opcode, step<=1, go to EXEC.
  - On an edge with en=1 and halt_req=1: go to HALT, IR unchanged.
- EXEC:
  - ctrl_word = store[{IR, flag_c, flag_z, step}].ctrl, combinational from registered IR/step and live flags (zero added latency).
  - On an edge with en=1: if entry.last=1 or step==STEPS-1, go to FETCH with step<=0; else step<=step+1.
  - Flags changing mid-step change ctrl_word in the same cycle.
- HALT:
  - ctrl_word=0, halted=1.
  - On an edge with en=1 and halt_req=0: go to FETCH with step=0.
- en=0 freezes state and step. ctrl_word still follows live flags in EXEC.
- Control store:
  - Depth 2^(OPC_W+2+STEP_W), asynchronous read, synchronous write.
  - uc_we is independent of en and state.
  - A write to the currently addressed entry shows on ctrl_word the cycle after the edge.
  - Entries at step 0 are unused; writes to them are accepted and ignored by the read path.
- Reset asserted mid-instruction aborts immediately to FETCH; store contents are kept.

Optional Feature:
- UCODE_PARITY_EN defined:
  - Entries are CW_W+2 wide; MSB is even parity over {last, ctrl}.
  - A parity mismatch on an EXEC read forces ctrl_word=0 that cycle.
  - The mismatch sets par_err on the next edge; par_err clears only on reset.
  - Sequencing continues normally.
- UCODE_PARITY_EN undefined:
  - Entries are CW_W+1 wide; uc_wdata is CW_W+1.
  - par_err is tied to 0.

Test Plan:
- Reset then en=1, halt_req=0 -> ctrl_word=13'h1008, fetch=1, step=0; after one edge with opcode=4'h2, step=1 and fetch=0.
- Write store[{4'h2,0,0,1}]={0,13'h0242} and store[{4'h2,0,0,2}]={1,13'h1260}; run opcode 2 with c=z=0 -> words 1008, 0242, 1260, 1008, with return to fetch after step 2.
- Opcode 8 with step-1 entries c=0/z=1 -> 13'h0808 and c=0/z=0 -> 13'h1008, both last=1; toggle flag_z during step 1 -> ctrl_word switches the same cycle, then returns to fetch.
- All entries last=0 for opcode 4 -> steps 0,1,2,3,0 (forced wrap at STEPS-1).
- halt_req=1 at fetch -> halted=1, ctrl_word=0 while held; drop halt_req -> fetch on the next edge. rst_n pulsed low during step 2 -> step=0 immediately, asynchronously.
- (UCODE_PARITY_EN) write an entry with bad parity and execute it -> ctrl_word=0 that step, par_err=1 from the next edge and sticky until reset.
